// File: rtl/nmac_ingress_filter_pkg.sv
// nmac_ingress_filter_pkg: shared types and constants for the NMAC ingress filter.
// Holds the 134-bit word layout, tag codes, FSM encoding, the default NMAC
// Ethertype/subtype and the header-match helper.
package nmac_ingress_filter_pkg;

  localparam int unsigned WORD_W    = 134;
  localparam int unsigned PAYLOAD_W = 128;
  localparam int unsigned CNT_W     = 32;

  localparam logic [1:0] TAG_INVALID = 2'b00;
  localparam logic [1:0] TAG_HEAD    = 2'b01;
  localparam logic [1:0] TAG_BODY    = 2'b11;
  localparam logic [1:0] TAG_TAIL    = 2'b10;

  localparam logic [15:0] NMAC_ETHERTYPE = 16'hFF01;
  localparam logic [7:0]  NMAC_SUBTYPE   = 8'h04;

  typedef enum logic [1:0] {
    ST_WAIT_HEAD = 2'd0,
    ST_CLASSIFY  = 2'd1,
    ST_FWD       = 2'd2
  } state_e;

  // Packet word: tag, four reserved bits, payload.
  typedef struct packed {
    logic [1:0]           tag;
    logic [3:0]           rsvd;
    logic [PAYLOAD_W-1:0] payload;
  } word_t;

  // hdr is payload[31:8] of the Ethernet-header word: {ethertype, subtype}.
  function automatic logic is_nmac_hdr(input logic [23:0] hdr,
                                       input logic [15:0] etype,
                                       input logic [7:0]  subtype);
    return (hdr[23:8] == etype) && (hdr[7:0] == subtype);
  endfunction

endpackage

// File: rtl/nmac_ingress_filter_if.sv
// nmac_ingress_filter_if: word-stream bundle between the receive path, the
// filter and its two downstream consumers.
//   master : upstream/observer side (drives iv_data, i_data_wr)
//   slave  : filter side (drives both output streams and the statistics)
interface nmac_ingress_filter_if;
  import nmac_ingress_filter_pkg::*;

  logic [WORD_W-1:0] iv_data;
  logic              i_data_wr;
  logic [WORD_W-1:0] ov_nmac_data;
  logic              o_nmac_data_wr;
  logic [WORD_W-1:0] ov_other_data;
  logic              o_other_data_wr;
  logic [CNT_W-1:0]  ov_nmac_pkt_cnt;
  logic [CNT_W-1:0]  ov_other_pkt_cnt;
  logic [CNT_W-1:0]  ov_err_cnt;

  modport master (
    output iv_data, i_data_wr,
    input  ov_nmac_data, o_nmac_data_wr, ov_other_data, o_other_data_wr,
    input  ov_nmac_pkt_cnt, ov_other_pkt_cnt, ov_err_cnt
  );

  modport slave (
    input  iv_data, i_data_wr,
    output ov_nmac_data, o_nmac_data_wr, ov_other_data, o_other_data_wr,
    output ov_nmac_pkt_cnt, ov_other_pkt_cnt, ov_err_cnt
  );

endinterface

// File: rtl/nmac_sat_counter.sv
// nmac_sat_counter: 32-bit counter that sticks at all-ones.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_clr        : synchronous clear (wins over increment)
//   i_inc        : count one event
//   ov_cnt       : current count
module nmac_sat_counter
  import nmac_ingress_filter_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] ov_cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ov_cnt = cnt_q;

endmodule

// File: rtl/nmac_ingress_filter.sv
// nmac_ingress_filter: steers NMAC configuration frames (Ethertype/subtype
// match on word 1) to the NMAC parser port and all other frames to the
// bypass port, with a fixed two-cycle latency (hold register s1, then the
// output register). Malformed frames are closed with a forced tail.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus (slave)  : iv_data/i_data_wr in; ov_nmac_data/o_nmac_data_wr and
//                  ov_other_data/o_other_data_wr out; three statistics counters
// Build option: define NMAC_FILTER_STAT_EN to implement the saturating
// frame/error counters; otherwise the counter outputs are tied to zero.
module nmac_ingress_filter
  import nmac_ingress_filter_pkg::*;
#(
  parameter logic [15:0] ETHERTYPE = NMAC_ETHERTYPE,
  parameter logic [7:0]  SUBTYPE   = NMAC_SUBTYPE
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  nmac_ingress_filter_if.slave bus
);

  state_e state_q, state_d;
  word_t  s1_q, s1_d;
  logic   s1_vld_q, s1_vld_d;
  logic   route_q, route_d;       // 1: current frame goes to the NMAC port

  word_t  nmac_data_q, other_data_q;
  logic   nmac_wr_q, other_wr_q;

  word_t  in_word;
  logic   in_head, in_tail, in_cont, hit;

  logic   emit_c;                  // s1 leaves for an output register this cycle
  logic   emit_nmac_c;             // ... on the NMAC port (else bypass)
  logic   force_tail_c;            // ... with its tag overwritten to tail
  word_t  out_word_c;

  assign in_word = word_t'(bus.iv_data);
  assign in_head = bus.i_data_wr && (in_word.tag == TAG_HEAD);
  assign in_tail = bus.i_data_wr && (in_word.tag == TAG_TAIL);
  assign in_cont = bus.i_data_wr && ((in_word.tag == TAG_BODY) || (in_word.tag == TAG_TAIL));
  assign hit     = is_nmac_hdr(in_word.payload[31:8], ETHERTYPE, SUBTYPE);

  // State, hold register and route flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_WAIT_HEAD;
      s1_q     <= '0;
      s1_vld_q <= 1'b0;
      route_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      s1_q     <= s1_d;
      s1_vld_q <= s1_vld_d;
      route_q  <= route_d;
    end
  end

  // Next state and emit decision for the word currently held in s1.
  always_comb begin
    state_d      = state_q;
    s1_d         = s1_q;
    s1_vld_d     = s1_vld_q;
    route_d      = route_q;
    emit_c       = 1'b0;
    emit_nmac_c  = route_q;
    force_tail_c = 1'b0;
    case (state_q)
      ST_WAIT_HEAD: begin
        // s1 may still hold the tail captured on the previous cycle.
        emit_c   = s1_vld_q;
        s1_vld_d = 1'b0;
        if (in_head) begin
          s1_d     = in_word;
          s1_vld_d = 1'b1;
          state_d  = ST_CLASSIFY;
        end
      end
      ST_CLASSIFY: begin
        emit_c = 1'b1;
        if (in_cont) begin
          // Word 1 decides the route for the held head and the rest of the frame.
          emit_nmac_c = hit;
          route_d     = hit;
          s1_d        = in_word;
          state_d     = in_tail ? ST_WAIT_HEAD : ST_FWD;
        end else if (in_head) begin
          emit_nmac_c = 1'b0;
          s1_d        = in_word;
        end else begin
          emit_nmac_c  = 1'b0;
          force_tail_c = 1'b1;
          s1_vld_d     = 1'b0;
          state_d      = ST_WAIT_HEAD;
        end
      end
      ST_FWD: begin
        emit_c = 1'b1;
        if (in_cont) begin
          s1_d = in_word;
          if (in_tail) begin
            state_d = ST_WAIT_HEAD;
          end
        end else if (in_head) begin
          force_tail_c = 1'b1;
          s1_d         = in_word;
          state_d      = ST_CLASSIFY;
        end else begin
          force_tail_c = 1'b1;
          s1_vld_d     = 1'b0;
          state_d      = ST_WAIT_HEAD;
        end
      end
      default: begin
        state_d  = ST_WAIT_HEAD;
        s1_vld_d = 1'b0;
      end
    endcase
  end

  // Outgoing word, tag overwritten when the frame is being closed early.
  always_comb begin
    out_word_c = s1_q;
    if (force_tail_c) begin
      out_word_c.tag = TAG_TAIL;
    end
  end

  // Output registers; each data register only loads when its port fires.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      nmac_data_q  <= '0;
      other_data_q <= '0;
      nmac_wr_q    <= 1'b0;
      other_wr_q   <= 1'b0;
    end else begin
      nmac_wr_q  <= emit_c & emit_nmac_c;
      other_wr_q <= emit_c & ~emit_nmac_c;
      if (emit_c & emit_nmac_c) begin
        nmac_data_q <= out_word_c;
      end
      if (emit_c & ~emit_nmac_c) begin
        other_data_q <= out_word_c;
      end
    end
  end

  assign bus.ov_nmac_data    = nmac_data_q;
  assign bus.o_nmac_data_wr  = nmac_wr_q;
  assign bus.ov_other_data   = other_data_q;
  assign bus.o_other_data_wr = other_wr_q;

`ifdef NMAC_FILTER_STAT_EN
  logic emit_tail_c;
  logic nmac_pkt_inc_c;
  logic other_pkt_inc_c;
  logic err_inc_c;

  // A frame is counted when its (possibly forced) tail leaves on a port.
  assign emit_tail_c     = emit_c && (out_word_c.tag == TAG_TAIL);
  assign nmac_pkt_inc_c  = emit_tail_c && emit_nmac_c;
  assign other_pkt_inc_c = emit_tail_c && !emit_nmac_c;
  // Errors: any forced tail, or a head arriving while a head is still held.
  assign err_inc_c       = force_tail_c || ((state_q == ST_CLASSIFY) && in_head);

  nmac_sat_counter u_nmac_pkt_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (1'b0),
    .i_inc  (nmac_pkt_inc_c),
    .ov_cnt (bus.ov_nmac_pkt_cnt)
  );

  nmac_sat_counter u_other_pkt_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (1'b0),
    .i_inc  (other_pkt_inc_c),
    .ov_cnt (bus.ov_other_pkt_cnt)
  );

  nmac_sat_counter u_err_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (1'b0),
    .i_inc  (err_inc_c),
    .ov_cnt (bus.ov_err_cnt)
  );
`else
  assign bus.ov_nmac_pkt_cnt  = CNT_W'(0);
  assign bus.ov_other_pkt_cnt = CNT_W'(0);
  assign bus.ov_err_cnt       = CNT_W'(0);
`endif

endmodule
